radix4_down_counter: RTL and testbench
======================================

Name: radix4_down_counter

Overview:
- Parametrised, registered successor to the combinational 3-bit decrementer.
- Loadable down-counter with enable, selectable step (1 or 2) and a start/busy/done handshake.
- Sequences the radix-4 Booth iterations in the multiplier datapath: loaded with the iteration count, decremented once per partial-product step, pulses terminal count on the last step.
- Saturates at zero; there is no wrap-around.

Parameters:
- WIDTH, 3, counter width in bits (legal range 2..16).
- RST_VAL, 0, count value after reset. Must fit in WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- load  input  1  load load_val into the counter.
- load_val  input  WIDTH  initial count.
- en  input  1  decrement enable, honoured only in RUN.
- step2  input  1  0 = decrement by 1, 1 = decrement by 2 (radix-4 double-bit skip). Sampled with en.
- count  output  WIDTH  current registered count.
- busy  output  1  high in RUN.
- zero  output  1  combinational, count == 0.
- tc  output  1  one-cycle terminal-count pulse, registered.

Behaviour:
- Reset (rst=1 at a clk edge): count=RST_VAL, state IDLE, busy=0, tc=0. Reset overrides load and en in the same cycle, and aborts a RUN mid-count with no tc.
- States: IDLE, RUN, DONE. busy=1 only in RUN.
- load=1 in any state (load has priority over en):
  - load_val != 0: count <= load_val, next state RUN, tc=0.
  - load_val == 0: count <= 0, next state DONE, tc pulses 1 the following cycle (zero-length job still signals completion).
- RUN, en=1: decrement d = step2 ? 2 : 1.
  - count > d: count <= count - d, stay RUN.
  - count <= d: count <= 0, tc <= 1 for exactly one cycle, next state DONE. Covers the saturating case, e.g. count=1 with step2=1 gives 0, never all-ones.
- RUN, en=0: hold count and state.
- IDLE/DONE, en=1 without load: ignored, count holds.
- DONE holds count=0 until the next load.
- Latency:
  - count updates on the clk edge that samples load/en.
  - tc is asserted in the cycle immediately after the edge where count reaches 0, coincident with state DONE.
- Arithmetic: unsigned, WIDTH bits. The internal subtract is WIDTH+1 bits so the borrow detects count < d. No modular wrap.
- Load during RUN restarts cleanly. If that same edge would also have produced tc, tc is suppressed.

Optional Feature:
- Macro: RADIX4_DOWN_COUNTER_RELOAD_EN.
- Defined:
  - A WIDTH-bit reload register captures load_val on every load.
  - On reaching 0 in RUN, count <= reload register and the state stays RUN; tc still pulses once per pass.
  - A new load or rst is the only exit. With reload value 0, the counter goes to DONE as in the non-reload case.
- Undefined: the reload register is not built; behaviour is exactly as above (DONE and hold at 0).

Test Plan:
- Reset/hold: rst=1 for 2 cycles, then en=1 with no load -> count=0 (RST_VAL), busy=0, tc never asserts.
- Step-1 run: WIDTH=3, load_val=5, en=1 continuously, step2=0 -> count 5,4,3,2,1,0. tc=1 for exactly the cycle after count becomes 0; busy falls the same cycle.
- Step-2 saturate: load_val=5, step2=1 -> count 5,3,1,0. No wrap to 7, single tc pulse.
- Zero load and reload: load_val=0 -> DONE next cycle, tc=1 for one cycle. With RADIX4_DOWN_COUNTER_RELOAD_EN, load_val=3, step2=0 -> 3,2,1,0→3,2,...; tc pulses every 3 enabled cycles.
- Abort: load_val=7, 3 decrements, then rst=1 -> count=RST_VAL next cycle, no tc. Repeat with load_val=2 asserted on the tc-producing edge -> count=2, tc stays 0, busy stays 1.
- en gaps and width: WIDTH=8, load_val=200, en toggled 1/0 pseudo-randomly, step2=0 -> count decrements only on en=1 cycles. tc arrives after exactly 200 enabled cycles.

Source files
------------

// File: rtl/radix4_down_counter.sv
// Loadable saturating down-counter (step 1 or 2) with IDLE/RUN/DONE handshake and a
// registered terminal-count pulse. Define RADIX4_DOWN_COUNTER_RELOAD_EN for auto-reload.
module radix4_down_counter #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             step2,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             zero,
  output logic             tc
);

  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RST_VAL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             tc_q, tc_d;
  logic [WIDTH:0]   dec_ext;
  logic [WIDTH:0]   diff;
  logic             above_step;

`ifdef RADIX4_DOWN_COUNTER_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Extra borrow bit: count > d exactly when no borrow and a nonzero remainder.
  assign dec_ext    = step2 ? (WIDTH+1)'(2) : (WIDTH+1)'(1);
  assign diff       = {1'b0, count_q} - dec_ext;
  assign above_step = !diff[WIDTH] && (diff[WIDTH-1:0] != '0);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
`ifdef RADIX4_DOWN_COUNTER_RELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
`ifdef RADIX4_DOWN_COUNTER_RELOAD_EN
      reload_d = load_val;
`endif
      count_d = load_val;
      if (load_val != '0) begin
        state_d = S_RUN;
      end else begin
        state_d = S_DONE;
        tc_d    = 1'b1;
      end
    end else if (state_q == S_RUN && en) begin
      if (above_step) begin
        count_d = diff[WIDTH-1:0];
      end else begin
        tc_d = 1'b1;
`ifdef RADIX4_DOWN_COUNTER_RELOAD_EN
        if (reload_q != '0) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = S_DONE;
        end
`else
        count_d = '0;
        state_d = S_DONE;
`endif
      end
    end
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= RST_COUNT;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
`ifdef RADIX4_DOWN_COUNTER_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      tc_q    <= tc_d;
`ifdef RADIX4_DOWN_COUNTER_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign tc    = tc_q;
  assign zero  = (count_q == '0);

endmodule

// File: tb/tb_radix4_down_counter.sv
// Self-checking bench for radix4_down_counter: WIDTH=3 and WIDTH=8 instances against
// an arithmetic reference model, directed test-plan steps plus a randomized phase.
module tb_radix4_down_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld [2];
  logic [7:0] lv [2];
  logic       en [2];
  logic       s2 [2];

  logic [2:0] count3;
  logic [7:0] count8;
  logic       busy3, zero3, tc3, busy8, zero8, tc8;

  int checks = 0;
  int errors = 0;

  int m_cnt [2];
  int m_rel [2];
  bit m_run [2];
  bit m_tc  [2];

  always #5 clk = ~clk;

  radix4_down_counter #(.WIDTH(3), .RST_VAL(0)) dut3 (
    .clk(clk), .rst(rst), .load(ld[0]), .load_val(lv[0][2:0]), .en(en[0]), .step2(s2[0]),
    .count(count3), .busy(busy3), .zero(zero3), .tc(tc3)
  );

  radix4_down_counter #(.WIDTH(8), .RST_VAL(0)) dut8 (
    .clk(clk), .rst(rst), .load(ld[1]), .load_val(lv[1]), .en(en[1]), .step2(s2[1]),
    .count(count8), .busy(busy8), .zero(zero8), .tc(tc8)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: counter as a plain integer that never drops below zero.
  task automatic model_step(input int i);
    int d;
    if (rst) begin
      m_cnt[i] = 0; m_run[i] = 0; m_tc[i] = 0; m_rel[i] = 0;
    end else if (ld[i]) begin
      m_cnt[i] = lv[i]; m_rel[i] = lv[i];
      m_run[i] = (lv[i] != 0);
      m_tc[i]  = (lv[i] == 0);
    end else if (m_run[i] && en[i]) begin
      d = s2[i] ? 2 : 1;
      if (m_cnt[i] > d) begin
        m_cnt[i] = m_cnt[i] - d;
        m_tc[i]  = 0;
      end else begin
        m_tc[i] = 1;
`ifdef RADIX4_DOWN_COUNTER_RELOAD_EN
        m_cnt[i] = m_rel[i];
        m_run[i] = (m_rel[i] != 0);
`else
        m_cnt[i] = 0;
        m_run[i] = 0;
`endif
      end
    end else begin
      m_tc[i] = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    chk("count3", int'(count3), m_cnt[0]);
    chk("busy3",  int'(busy3),  int'(m_run[0]));
    chk("tc3",    int'(tc3),    int'(m_tc[0]));
    chk("zero3",  int'(zero3),  int'(m_cnt[0] == 0));
    chk("count8", int'(count8), m_cnt[1]);
    chk("busy8",  int'(busy8),  int'(m_run[1]));
    chk("tc8",    int'(tc8),    int'(m_tc[1]));
    chk("zero8",  int'(zero8),  int'(m_cnt[1] == 0));
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      ld[i] = 1'b0; lv[i] = '0; en[i] = 1'b0; s2[i] = 1'b0;
    end
  endtask

  task automatic load3(input int v);
    ld[0] = 1'b1; lv[0] = 8'(v); en[0] = 1'b0;
    cyc();
    ld[0] = 1'b0;
  endtask

  initial begin
    int seq1 [6];
    int seq2 [4];
    int tc_seen;
    int en_cnt;
    int budget;
    seq1 = '{5, 4, 3, 2, 1, 0};
    seq2 = '{5, 3, 1, 0};

    idle_inputs();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_rel[i] = 0; m_run[i] = 0; m_tc[i] = 0;
    end
    cyc();
    en[0] = 1'b1; en[1] = 1'b1;
    cyc();
    chk("reset_count3", int'(count3), 0);
    chk("reset_busy3", int'(busy3), 0);

    // Enable without load is ignored outside RUN.
    rst = 1'b0;
    tc_seen = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      tc_seen += int'(tc3) + int'(tc8);
    end
    chk("hold_no_tc", tc_seen, 0);
    chk("hold_count8", int'(count8), 0);

    // Step-1 run from 5.
    load3(5);
    chk("step1_seq0", int'(count3), seq1[0]);
    en[0] = 1'b1; s2[0] = 1'b0;
    for (int k = 1; k < 6; k++) begin
      cyc();
`ifndef RADIX4_DOWN_COUNTER_RELOAD_EN
      chk("step1_seq", int'(count3), seq1[k]);
`endif
    end
`ifndef RADIX4_DOWN_COUNTER_RELOAD_EN
    chk("step1_tc", int'(tc3), 1);
    chk("step1_busy", int'(busy3), 0);
`endif
    cyc();
    chk("step1_tc_once", int'(tc3), 0);

    // Step-2 saturates at zero rather than wrapping.
    load3(5);
    en[0] = 1'b1; s2[0] = 1'b1;
    for (int k = 1; k < 4; k++) begin
      cyc();
`ifndef RADIX4_DOWN_COUNTER_RELOAD_EN
      chk("step2_seq", int'(count3), seq2[k]);
`endif
    end
`ifndef RADIX4_DOWN_COUNTER_RELOAD_EN
    chk("step2_tc", int'(tc3), 1);
    cyc();
    chk("step2_nowrap", int'(count3), 0);
`endif
    idle_inputs();

    // Zero-length job.
    load3(0);
    chk("zload_tc", int'(tc3), 1);
    chk("zload_busy", int'(busy3), 0);
    cyc();
    chk("zload_tc_once", int'(tc3), 0);

`ifdef RADIX4_DOWN_COUNTER_RELOAD_EN
    // Auto-reload: tc every 3 enabled cycles, busy stays high.
    load3(3);
    en[0] = 1'b1; s2[0] = 1'b0;
    tc_seen = 0;
    for (int k = 0; k < 9; k++) begin
      cyc();
      tc_seen += int'(tc3);
    end
    chk("reload_tc_count", tc_seen, 3);
    chk("reload_busy", int'(busy3), 1);
    idle_inputs();
`endif

    // Reset aborts a run mid-count.
    load3(7);
    en[0] = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    chk("abort_pre", int'(count3), 4);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_count", int'(count3), 0);
    chk("abort_tc", int'(tc3), 0);

    // Load on the edge that would have produced tc.
    load3(7);
    en[0] = 1'b1;
    for (int k = 0; k < 6; k++) cyc();
    chk("reload_edge_pre", int'(count3), 1);
    ld[0] = 1'b1; lv[0] = 8'd2;
    cyc();
    ld[0] = 1'b0;
    chk("load_wins_count", int'(count3), 2);
    chk("load_wins_tc", int'(tc3), 0);
    chk("load_wins_busy", int'(busy3), 1);
    idle_inputs();

    // WIDTH=8: 200 with random enable gaps.
    ld[1] = 1'b1; lv[1] = 8'd200;
    cyc();
    ld[1] = 1'b0;
    en_cnt = 0;
    budget = 0;
    while (!tc8 && budget < 2000) begin
      en[1] = 1'($urandom_range(0, 1));
      if (en[1]) en_cnt++;
      cyc();
      budget++;
    end
    chk("w8_tc_seen", int'(tc8), 1);
    chk("w8_enabled_cycles", en_cnt, 200);
    idle_inputs();

    // Randomized traffic on both instances.
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < 2; i++) begin
        ld[i] = ($urandom_range(0, 11) == 0);
        lv[i] = (i == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 20));
        en[i] = 1'($urandom_range(0, 3) != 0);
        s2[i] = 1'($urandom_range(0, 1));
      end
      cyc();
    end
    rst = 1'b0;
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
